// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential 4x4 shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned ITERS  = WIDTH;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_add.sv
// 4-bit ripple-carry adder; c_out exposes the carry out of every bit position.
module seq_mult_ctrl_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic [3:0] c_out
);

    logic [4:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c_out[i] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        assign c[i+1]   = c_out[i];
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: one shared 4-bit adder, ITERS add/shift steps,
// valid/ready handshakes on operands and product.
module seq_mult_ctrl
    import mult_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   Product
);

    if (WIDTH != 4) begin : g_width_chk
        $error("seq_mult_ctrl: WIDTH must be 4, the adder is 4 bits wide");
    end

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   carry;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               unused_carry;

    assign add_b = lo_q[0] ? mcand_q : '0;

    seq_mult_ctrl_add u_add (
        .a     (hi_q),
        .b     (add_b),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (carry)
    );

    // Only the final carry feeds the partial product.
    assign unused_carry = ^carry[WIDTH-2:0];

    // One iteration: {carry, sum, lo} shifted right by one.
    always_comb begin
        hi_d = {carry[WIDTH-1], sum[WIDTH-1:1]};
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= A;
                        hi_q    <= '0;
                        lo_q    <= B;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Product   = {hi_q, lo_q};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and randomised checks of seq_mult_ctrl: latency, handshakes, products, reset.
module tb_seq_mult_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Product;

    int checks = 0;
    int errors = 0;

    seq_mult_ctrl dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Product   (Product)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single transaction with out_ready held high; expects fixed 4-edge latency.
    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int exp, input string tag);
        int n;
        chk({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_product"}, 32'(Product), 32'(exp));
        chk({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_vld_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int ra, rb;
        int outs;
        int overlap;
        bit done;

        Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;

        // Reset asserted between edges must act immediately.
        #3 Reset = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(Product), 32'h00);
        chk("rst_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        run_txn(4'd7, 4'd6, 42, "m7x6");
        run_txn(4'd15, 4'd15, 225, "m15x15");
        run_txn(4'd0, 4'd9, 0, "m0x9");
        run_txn(4'd9, 4'd0, 0, "m9x0");

        // Backpressure: product held while out_ready low, in_valid ignored in DONE.
        A = 4'd3; B = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_latency", 32'(n), 32'd4);
        A = 4'd9; B = 4'd9; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_product", 32'(Product), 32'h0F);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_product", 32'(Product), 32'h0F);
        tick();
        chk("bp_stay_idle", 32'(in_ready), 32'd1);

        // Reset after two iterations discards the operation.
        A = 4'd12; B = 4'd11; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 Reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_product", 32'(Product), 32'h00);
        tick();
        Reset = 1'b0;
        tick();
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        run_txn(4'd2, 4'd3, 6, "m2x3");

        // Random transactions with random output stalls.
        outs = 0;
        overlap = 0;
        for (int t = 0; t < 200; t++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            chk("rnd_ready", 32'(in_ready), 32'd1);
            A = 4'(ra); B = 4'(rb); in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            tick();
            in_valid = 1'b0;
            A = 4'($urandom_range(0, 15));
            B = 4'($urandom_range(0, 15));
            n = 0;
            done = 1'b0;
            while (!done && n < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (in_ready === 1'b1 && out_valid === 1'b1) overlap++;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    chk("rnd_product", 32'(Product), 32'(ra * rb));
                    outs++;
                    done = 1'b1;
                end
                tick();
                n++;
            end
            chk("rnd_completed", 32'(done), 32'd1);
        end
        out_ready = 1'b0;
        chk("rnd_output_count", 32'(outs), 32'd200);
        chk("rnd_ready_valid_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
